// File: rtl/shift_mult_ctrl_if.sv
// shift_mult_ctrl_if: request/strobe bundle between the shift-add multiplier controller and its datapath.
interface shift_mult_ctrl_if #(parameter int CW = 5);
  logic start, abort, lsb;
  logic ld, shen, acc_clr, acc_ld, busy, done;
  logic [CW-1:0] cnt;
  modport master(output start, abort, lsb, input ld, shen, acc_clr, acc_ld, busy, done, cnt);
  modport slave(input start, abort, lsb, output ld, shen, acc_clr, acc_ld, busy, done, cnt);
endinterface

// File: rtl/shift_mult_ctrl.sv
// shift_mult_ctrl: sequences load, N shift/add steps and a done pulse for a shift-add multiplier.
module shift_mult_ctrl #(
  parameter int N  = 16,
  parameter int CW = 5
) (
  input logic clk,
  input logic clr,
  shift_mult_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t st;
  logic ld, shen, acc_clr, busy, done;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      st <= IDLE;
      ld <= 1'b0;
      shen <= 1'b0;
      acc_clr <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
    end else begin
      ld <= 1'b0;
      acc_clr <= 1'b0;
      done <= 1'b0;
      case (st)
        IDLE: if (bus.start && !bus.abort) begin
          st <= LOAD;
          ld <= 1'b1;
          acc_clr <= 1'b1;
          busy <= 1'b1;
          cnt <= '0;
        end
        LOAD: if (bus.abort) begin
          st <= IDLE;
          busy <= 1'b0;
        end else begin
          st <= RUN;
          shen <= 1'b1;
        end
        RUN: if (bus.abort) begin
          st <= IDLE;
          shen <= 1'b0;
          busy <= 1'b0;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            st <= DONE;
            shen <= 1'b0;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        DONE: begin
          st <= IDLE;
          cnt <= '0;
        end
        default: st <= IDLE;
      endcase
    end
  end
  // Only the accumulator load follows an input directly: add when the outgoing multiplier bit is 1.
  assign bus.acc_ld  = shen & bus.lsb;
  assign bus.ld      = ld;
  assign bus.shen    = shen;
  assign bus.acc_clr = acc_clr;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.cnt     = cnt;
endmodule

// File: tb/tb_shift_mult_ctrl.sv
// tb_shift_mult_ctrl: random and directed stimulus against a latency-based reference model plus completion scoreboard.
module tb_shift_mult_ctrl;
  localparam int N = 16;
  localparam int CW = 5;
  typedef struct {logic [N-1:0] w; int t;} exp_t;
  logic clk = 1'b0, clr = 1'b0;
  logic [N-1:0] word_cur = '1, ld_word = '0, sr = '0, cap = '0;
  exp_t sb[$];
  int dq[$];
  int cyc = 0, off = 0, ones = 0, passed = 0, total = 0;
  bit act = 0, dflag = 0;
  shift_mult_ctrl_if #(.CW(CW)) bus();
  shift_mult_ctrl #(.N(N), .CW(CW)) dut(.clk(clk), .clr(clr), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %0h expected %0h at edge %0d", nm, a, e, cyc);
    else passed++;
  endtask
  // Datapath stand-in: the multiplier shift register the controller drives.
  always @(posedge clk) if (bus.ld) sr <= ld_word; else if (bus.shen) sr <= sr >> 1;
  assign bus.lsb = sr[0];
  // Reference model: off = clock edges since the accepted start (1 load, 2..N+1 run, N+2 done).
  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      if (act && off < N + 2 && sb.size() > 0) void'(sb.pop_back());
      act <= 0;
      off <= 0;
    end else begin
      cyc <= cyc + 1;
      if (!act) begin
        if (bus.start && !bus.abort) begin
          act <= 1;
          off <= 1;
          ld_word <= word_cur;
          sb.push_back('{w: word_cur, t: cyc + N + 2});
        end
      end else if (off == N + 2 || bus.abort) begin
        if (off != N + 2) void'(sb.pop_back());
        act <= 0;
        off <= 0;
      end else off <= off + 1;
    end
  end
  always @(negedge clk) begin
    bit e_ld, e_shen, e_busy, e_done;
    e_ld = act && off == 1;
    e_shen = act && off >= 2 && off <= N + 1;
    e_busy = act && off >= 1 && off <= N + 1;
    e_done = act && off == N + 2;
    chk("ld", bus.ld, e_ld);
    chk("acc_clr", bus.acc_clr, e_ld);
    chk("shen", bus.shen, e_shen);
    chk("busy", bus.busy, e_busy);
    chk("done", bus.done, e_done);
    chk("acc_ld", bus.acc_ld, e_shen & bus.lsb);
    chk("cnt", bus.cnt, (!act || off < 2) ? 0 : off - 2);
  end
  // Completion monitor: collects the acc_ld stream and checks it against the queued operation.
  always @(negedge clk) begin
    if (bus.ld) begin
      cap = '0;
      ones = 0;
    end else if (bus.shen) begin
      cap = {bus.acc_ld, cap[N-1:1]};
      ones += int'(bus.acc_ld);
    end
    if (bus.done) begin
      if (dflag) dq.push_back(cyc);
      if (sb.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_time", cyc, e.t);
        chk("acc_pattern", cap, e.w);
        chk("acc_count", ones, $countones(e.w));
        chk("done_cnt", bus.cnt, N);
      end
    end
  end
  task automatic go();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_cnt", bus.cnt, 0);
    @(negedge clk) clr = 1'b1;
    word_cur = '1;
    go();
    repeat (21) @(negedge clk);
    word_cur = N'(16'hA5A5);
    go();
    repeat (21) @(negedge clk);
    word_cur = N'($urandom);
    go();
    repeat (5) @(negedge clk);
    chk("abort_cnt_before", bus.cnt, 4);
    bus.abort = 1'b1;
    @(negedge clk) bus.abort = 1'b0;
    chk("abort_cnt", bus.cnt, 0);
    chk("abort_busy", bus.busy, 0);
    repeat (3) @(negedge clk);
    word_cur = N'($urandom);
    go();
    repeat (10) @(negedge clk);
    #2 clr = 1'b0;
    #1;
    chk("aclr_shen", bus.shen, 0);
    chk("aclr_busy", bus.busy, 0);
    chk("aclr_cnt", bus.cnt, 0);
    chk("aclr_acc_ld", bus.acc_ld, 0);
    @(negedge clk) clr = 1'b1;
    repeat (2) @(negedge clk);
    word_cur = N'($urandom);
    go();
    repeat (21) @(negedge clk);
    dflag = 1;
    bus.start = 1'b1;
    repeat (40) @(negedge clk) word_cur = N'($urandom);
    bus.start = 1'b0;
    dflag = 0;
    chk("b2b_third_busy", bus.busy, 1);
    chk("b2b_dones", dq.size(), 2);
    if (dq.size() == 2) chk("b2b_spacing", dq[1] - dq[0], N + 3);
    repeat (25) @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    repeat (3) @(negedge clk);
    chk("start_abort_busy", bus.busy, 0);
    chk("start_abort_ld", bus.ld, 0);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (400) @(negedge clk) begin
      bus.start = ($urandom_range(3) == 0);
      bus.abort = ($urandom_range(15) == 0);
      word_cur = N'($urandom);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (25) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/shift_mult_ctrl.md
SHIFT_MULT_CTRL -- requirements
Module: shift_mult_ctrl

Interface
REQ-001 Parameter N, default 16: number of shift steps per operation, equal to the width of the controlled right-shift register.
REQ-002 Parameter CW, default 5: counter width; SHALL satisfy 2^CW > N.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  operation request; sampled only in IDLE.
REQ-006 abort  input  1  synchronous cancel; honoured in LOAD and RUN.
REQ-007 lsb  input  1  bit currently leaving the shift register (multiplier LSB).
REQ-008 ld  output  1  parallel-load strobe to shift register.
REQ-009 shen  output  1  shift-enable to shift register.
REQ-010 acc_clr  output  1  clear strobe to accumulator.
REQ-011 acc_ld  output  1  accumulator load (add partial product).
REQ-012 busy  output  1  high in LOAD and RUN.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 cnt  output  CW  current step count.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, RUN, DONE; exactly one active per cycle.
REQ-016 IDLE: all strobes 0, busy=0, cnt=0; start=1 and abort=0 -> LOAD; otherwise stay.
REQ-017 LOAD: ld=1, acc_clr=1, busy=1, cnt cleared to 0; next state RUN unless abort=1 (-> IDLE).
REQ-018 RUN: shen=1, busy=1, cnt increments by 1 each cycle; acc_ld SHALL equal lsb combinationally (only output allowed to depend on an input).
REQ-019 RUN exit: in the cycle where cnt==N-1, shen still asserted; next state DONE, so RUN lasts exactly N cycles.
REQ-020 DONE: done=1 for exactly one cycle, busy=0, cnt holds N; next state IDLE unconditionally; start in DONE SHALL be ignored.
REQ-021 Entering IDLE SHALL clear cnt to 0.
REQ-022 Latency: start sampled at edge k -> ld high cycle k+1, shen high cycles k+2..k+N+1, done high cycle k+N+2; earliest next start sampled at edge k+N+3.
REQ-023 ld and shen SHALL never be high in the same cycle; acc_ld SHALL be 0 outside RUN.
REQ-024 abort=1 in LOAD or RUN -> IDLE at next edge, no done pulse, cnt cleared; abort in IDLE/DONE has no effect except abort=1 in IDLE blocks start.
REQ-025 cnt SHALL never exceed N; no wrap-around within an operation.
REQ-026 start held continuously high SHALL yield back-to-back operations separated by one IDLE cycle.

Reset
REQ-027 clr=0 SHALL immediately (no clock) force IDLE, cnt=0, and ld, shen, acc_clr, acc_ld, busy, done all 0.
REQ-028 clr asserted mid-RUN SHALL abandon the operation; after release the block waits in IDLE for a new start.
REQ-029 First rising edge after clr deassertion SHALL be treated as a normal IDLE evaluation.

Verification
REQ-030 Reset then single start pulse, N=16, lsb=1 -> ld one cycle, shen 16 cycles, acc_ld 16 cycles, done at cycle 18 after start edge, cnt=16 in DONE.
REQ-031 lsb pattern 0xA5A5 shifted LSB-first -> acc_ld sequence 1,0,1,0,0,1,0,1,... matching lsb each RUN cycle, 8 acc_ld pulses total.
REQ-032 abort=1 at RUN cycle 5 (cnt=4) -> IDLE next edge, cnt=0, no done, busy=0.
REQ-033 clr low at RUN cycle 10 -> outputs 0 asynchronously before next edge; after release start re-launches full 16-step run.
REQ-034 start held high 40 cycles -> two complete operations, done pulses 19 cycles apart, third launch pending at end.
REQ-035 start and abort both high in IDLE -> stays IDLE, no ld.
